ed_adaptive_detector: RTL
=========================

ED_ADAPTIVE_DETECTOR -- requirements
Module: ed_adaptive_detector

Interface
REQ-001 SHALL provide parameters: DATA_W, default 16, sample width (signed); K_DELAY, default 2, difference lag in samples (1..15); TRAIN_LOG2, default 8, training length 2^TRAIN_LOG2 energies; THR_SHIFT, default 3, threshold gain 2^THR_SHIFT; THR_MIN, default 500, threshold floor; REFRACT, default 32, refractory length in accepted samples.
REQ-002 SHALL provide ports: clk input 1, single clock, rising edge; rst input 1, synchronous active-high reset.
REQ-003 SHALL provide ports: in_valid input 1, sample strobe; data_in input DATA_W signed, sample; retrain input 1, one-cycle request to restart training.
REQ-004 SHALL provide ports: out_valid output 1, result strobe; spike_detected output 1, spike flag qualified by out_valid; energy output EW=2*DATA_W+2 unsigned, squared difference; threshold output EW, active threshold; training_done output 1, high in OPERATE.

Function
REQ-005 SHALL keep a shift buffer of K_DELAY+1 samples advancing only on cycles with in_valid=1; idle cycles SHALL change no state except retrain handling.
REQ-006 SHALL compute d = x[n] - x[n-K_DELAY] at DATA_W+1 bits and energy = d*d at EW bits, with no overflow for any input pair.
REQ-007 SHALL implement states FILL, TRAIN, OPERATE; FILL -> TRAIN after K_DELAY+1 accepted samples; TRAIN -> OPERATE after 2^TRAIN_LOG2 accepted energies.
REQ-008 SHALL, in TRAIN, accumulate energies into an accumulator of EW+TRAIN_LOG2 bits, cleared on entry to TRAIN.
REQ-009 SHALL, on TRAIN -> OPERATE, load threshold = max(THR_MIN, (acc >> TRAIN_LOG2) << THR_SHIFT), saturated to 2^EW-1.
REQ-010 SHALL, in OPERATE, assert out_valid exactly one cycle after each accepted sample (latency 1), with energy of that sample and spike_detected = (energy > threshold) strictly.
REQ-011 SHALL hold out_valid=0 and spike_detected=0 in FILL and TRAIN; spike_detected SHALL be 0 whenever out_valid=0.
REQ-012 SHALL, on retrain=1 in TRAIN or OPERATE, enter TRAIN next cycle, clear accumulator and training counter, keep buffer contents and keep threshold until the new value loads; a sample accepted in the same cycle SHALL shift into the buffer but not count towards training.
REQ-013 SHALL ignore retrain in FILL.
REQ-014 SHALL drop training_done on the cycle TRAIN is entered and raise it on the cycle threshold loads.

Reset
REQ-015 SHALL, with rst=1 at a rising edge, clear buffer, accumulator and counters, set state FILL, threshold=THR_MIN, energy=0, out_valid=0, spike_detected=0, training_done=0.
REQ-016 SHALL give rst priority over in_valid and retrain, including mid-TRAIN and mid-refractory.

Configuration
REQ-017 SHALL, with ED_REFRACTORY_EN defined, after each spike suppress spike_detected for the next REFRACT outputs (counter decrements per out_valid, cleared by rst or retrain); energy and out_valid unaffected.
REQ-018 SHALL, without ED_REFRACTORY_EN, flag every output whose energy exceeds threshold and contain no refractory counter.

Verification (DATA_W=16, K_DELAY=2, TRAIN_LOG2=4, THR_SHIFT=2, THR_MIN=100, REFRACT=4)
REQ-019 SHALL check: reset, 19 zero samples -> training_done rises after sample 19, threshold=100, no out_valid before then.
REQ-020 SHALL check: ramp data_in=5n for 19 samples -> threshold=400; then hold 0 twice and apply 30 -> energy=900, spike_detected=1 one cycle later; energy=400 -> no spike.
REQ-021 SHALL check: after training, data_in 32767 then hold, then -32768 at lag 2 -> energy=4294836225, no wrap.
REQ-022 SHALL check with ED_REFRACTORY_EN: 6 consecutive energies 900 -> spikes on outputs 1 and 6 only; without macro -> all 6 flagged.
REQ-023 SHALL check: rst at training sample 8 -> state FILL, training_done=0, threshold=100; full retraining then completes after 19 more samples.
REQ-024 SHALL check: retrain in OPERATE with in_valid gaps -> training_done low until 16 further accepted samples, old threshold held until reload.

Source files
------------

// File: rtl/ed_adaptive_detector.sv
// ed_adaptive_detector: lagged-difference energy spike detector with self-trained threshold.
// Optional refractory suppression after each spike is enabled by defining ED_REFRACTORY_EN.
module ed_adaptive_detector #(
  parameter int DATA_W     = 16,
  parameter int K_DELAY    = 2,
  parameter int TRAIN_LOG2 = 8,
  parameter int THR_SHIFT  = 3,
  parameter int THR_MIN    = 500,
  parameter int REFRACT    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic signed [DATA_W-1:0]   data_in,
  input  logic                       retrain,
  output logic                       out_valid,
  output logic                       spike_detected,
  output logic [2*DATA_W+1:0]        energy,
  output logic [2*DATA_W+1:0]        threshold,
  output logic                       training_done
);
  localparam int EW = 2*DATA_W+2;
  localparam int AW = EW+TRAIN_LOG2;
  localparam int SW = EW+THR_SHIFT+1;
  localparam int CW = (TRAIN_LOG2 > 4 ? TRAIN_LOG2 : 4) + 1;
  typedef enum logic [1:0] {FILL, TRAIN, OPERATE} state_t;
  state_t state, state_n;
  logic signed [DATA_W-1:0] sbuf [K_DELAY+1];
  logic signed [DATA_W:0] d;
  logic signed [EW-1:0] dx;
  logic [EW-1:0] e, thr_new;
  logic [AW-1:0] acc, acc_n;
  logic [SW-1:0] sh;
  logic [CW-1:0] cnt;
  logic retr, fill_done, train_done, emit, hit;
  // sbuf[K_DELAY-1] still holds x[n-K] because the shift happens at this same edge
  assign d = {data_in[DATA_W-1], data_in} - {sbuf[K_DELAY-1][DATA_W-1], sbuf[K_DELAY-1]};
  assign dx = {{(EW-DATA_W-1){d[DATA_W]}}, d};
  assign e = $unsigned(dx * dx);
  assign acc_n = acc + AW'(e);
  assign sh = SW'(acc_n[AW-1:TRAIN_LOG2]) << THR_SHIFT;
  assign thr_new = (sh[SW-1:EW] != '0) ? '1 : (sh[EW-1:0] < EW'(THR_MIN)) ? EW'(THR_MIN) : sh[EW-1:0];
  assign retr = retrain && state != FILL;
  assign fill_done = in_valid && state == FILL && cnt == CW'(K_DELAY);
  assign train_done = in_valid && !retr && state == TRAIN && cnt == CW'((1 << TRAIN_LOG2) - 1);
  assign emit = in_valid && state == OPERATE && !retr;
  assign training_done = state == OPERATE;
`ifdef ED_REFRACTORY_EN
  localparam int RW = $clog2(REFRACT+2);
  logic [RW-1:0] refr;
  assign hit = e > threshold && refr == '0;
  always_ff @(posedge clk)
    if (rst || retr) refr <= '0;
    else if (emit) refr <= hit ? RW'(REFRACT) : (refr != '0) ? refr - 1'b1 : refr;
`else
  assign hit = e > threshold;
`endif
  always_comb state_n = (retr || fill_done) ? TRAIN : train_done ? OPERATE : state;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      for (int i = 0; i <= K_DELAY; i++) sbuf[i] <= '0;
      acc <= '0;
      cnt <= '0;
      energy <= '0;
      threshold <= EW'(THR_MIN);
      out_valid <= 1'b0;
      spike_detected <= 1'b0;
    end else begin
      state <= state_n;
      if (in_valid) begin
        sbuf[0] <= data_in;
        for (int i = 1; i <= K_DELAY; i++) sbuf[i] <= sbuf[i-1];
        energy <= e;
      end
      out_valid <= emit;
      spike_detected <= emit && hit;
      cnt <= (retr || fill_done || train_done) ? '0 : (in_valid && state != OPERATE) ? cnt + 1'b1 : cnt;
      acc <= (retr || fill_done) ? '0 : (in_valid && state == TRAIN) ? acc_n : acc;
      if (train_done) threshold <= thr_new;
    end
  end
endmodule
